// File: rtl/hilo_muldiv_pkg.sv
// Shared decode definitions for the HI/LO multiply/divide unit.
// Holds the ALU_SEL_* and w_hilo_ena encodings used by decode and EX.
// Also holds the local FSM state encoding and small operand helpers.
package hilo_muldiv_pkg;

    // ALU operation codes shared with the decode stage
    localparam logic [5:0] ALU_SEL_ADD   = 6'h20;
    localparam logic [5:0] ALU_SEL_MULT  = 6'h18;
    localparam logic [5:0] ALU_SEL_MULTU = 6'h19;
    localparam logic [5:0] ALU_SEL_DIV   = 6'h1A;
    localparam logic [5:0] ALU_SEL_DIVU  = 6'h1B;

    // HI/LO write-enable encodings, bit 1 = HI and bit 0 = LO
    localparam logic [1:0] HILO_W_NONE = 2'b00;
    localparam logic [1:0] HILO_W_LO   = 2'b01;
    localparam logic [1:0] HILO_W_HI   = 2'b10;
    localparam logic [1:0] HILO_W_BOTH = 2'b11;

    // Multiply/divide sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_MUL  = 2'b01,
        ST_DIV  = 2'b10,
        ST_DONE = 2'b11
    } muldiv_state_e;

    localparam int CNT_W = 6;

    // True for the four operations that run on the multi-cycle unit
    function automatic logic is_muldiv_sel(input logic [5:0] sel);
        logic r;
        case (sel)
            ALU_SEL_MULT, ALU_SEL_MULTU, ALU_SEL_DIV, ALU_SEL_DIVU: r = 1'b1;
            default:                                                r = 1'b0;
        endcase
        return r;
    endfunction

    // True for the divide operations
    function automatic logic is_div_sel(input logic [5:0] sel);
        logic r;
        case (sel)
            ALU_SEL_DIV, ALU_SEL_DIVU: r = 1'b1;
            default:                   r = 1'b0;
        endcase
        return r;
    endfunction

    // True for the signed variants
    function automatic logic is_signed_sel(input logic [5:0] sel);
        logic r;
        case (sel)
            ALU_SEL_MULT, ALU_SEL_DIV: r = 1'b1;
            default:                   r = 1'b0;
        endcase
        return r;
    endfunction

    // Magnitude of a 32-bit value; only negated when treated as signed
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic sgn);
        logic [31:0] r;
        if (sgn && v[31]) begin
            r = ~v + 32'd1;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/hilo_muldiv_div.sv
// div_radix2: iterative restoring divider, one quotient bit per cycle.
// start latches operands (magnitudes plus sign fix-up flags); done pulses
// for one cycle after the 32nd iteration, while the result registers hold.
// abort cancels the operation without producing done.
module div_radix2 import hilo_muldiv_pkg::*; (
    input  logic        clk,
    input  logic        rst,
    input  logic        abort,
    input  logic        start,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    localparam logic [4:0] ITER_LAST = 5'd31;
    localparam logic [4:0] ITER_ZERO = 5'd0;
    localparam logic [4:0] ITER_ONE  = 5'd1;

    logic [31:0] rem_r;
    logic [31:0] quo_r;
    logic [31:0] bmag_r;
    logic [4:0]  cnt_r;
    logic        run_r;
    logic        done_r;
    logic        neg_q_r;
    logic        neg_r_r;

    logic [32:0] rem_sh_s;
    logic [33:0] diff_s;
    logic        fits_s;
    logic [31:0] rem_nx_s;
    logic [31:0] quo_nx_s;

    // One restoring step: shift {rem,quo} left, trial-subtract the divisor
    always_comb begin
        rem_sh_s = {rem_r, quo_r[31]};
        diff_s   = {1'b0, rem_sh_s} - {2'b00, bmag_r};
        fits_s   = ~diff_s[33];
        if (fits_s) begin
            rem_nx_s = diff_s[31:0];
        end else begin
            rem_nx_s = rem_sh_s[31:0];
        end
        quo_nx_s = {quo_r[30:0], fits_s};
    end

    // Operand latch, iteration counter and partial remainder/quotient
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_r   <= 32'd0;
            quo_r   <= 32'd0;
            bmag_r  <= 32'd0;
            cnt_r   <= ITER_ZERO;
            run_r   <= 1'b0;
            done_r  <= 1'b0;
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
        end else if (abort) begin
            run_r   <= 1'b0;
            done_r  <= 1'b0;
        end else if (start) begin
            rem_r   <= 32'd0;
            quo_r   <= abs32(dividend, is_signed);
            bmag_r  <= abs32(divisor, is_signed);
            cnt_r   <= ITER_LAST;
            run_r   <= 1'b1;
            done_r  <= 1'b0;
            neg_q_r <= is_signed & (dividend[31] ^ divisor[31]);
            neg_r_r <= is_signed & dividend[31];
        end else if (run_r) begin
            rem_r   <= rem_nx_s;
            quo_r   <= quo_nx_s;
            cnt_r   <= cnt_r - ITER_ONE;
            if (cnt_r == ITER_ZERO) begin
                run_r  <= 1'b0;
                done_r <= 1'b1;
            end else begin
                done_r <= 1'b0;
            end
        end else begin
            done_r  <= 1'b0;
        end
    end

    // Signed fix-up: quotient negative on sign mismatch, remainder follows dividend
    always_comb begin
        if (neg_q_r) begin
            quotient = ~quo_r + 32'd1;
        end else begin
            quotient = quo_r;
        end
        if (neg_r_r) begin
            remainder = ~rem_r + 32'd1;
        end else begin
            remainder = rem_r;
        end
        done = done_r;
    end

endmodule

// File: rtl/hilo_muldiv.sv
// hilo_muldiv: EX-stage multiply/divide unit holding the architectural HI/LO.
// Multiplies run MUL_CYCLES cycles with a registered product; divides use the
// div_radix2 sub-module (32 iterations). stall_req freezes IF/ID/EX until the
// DONE cycle, in which the stalled instruction advances and HI/LO are written.
// Optional build macro MULDIV_DIV_EARLY_OUT_EN: divides by zero or with
// |a| < |b| skip the iterations and finish in 2 cycles.
module hilo_muldiv import hilo_muldiv_pkg::*; #(
    parameter int MUL_CYCLES = 2,
    parameter int DIV_ITERS  = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        op_valid,
    input  logic [5:0]  alu_sel,
    input  logic [1:0]  w_hilo_ena,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        stall_req,
    output logic        busy,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_DIV_LOAD = CNT_W'(DIV_ITERS - 1);

    muldiv_state_e state_r;
    muldiv_state_e state_nx_s;

    logic [CNT_W-1:0] cnt_r;
    logic [31:0]      a_r;
    logic [31:0]      b_r;
    logic             signed_r;
    logic             is_div_r;
    logic             bzero_r;
    logic             early_r;
    logic [63:0]      prod_r;
    logic [31:0]      hi_r;
    logic [31:0]      lo_r;

    logic        start_s;
    logic        accept_s;
    logic        sel_div_s;
    logic        sel_signed_s;
    logic        early_s;
    logic        div_start_s;
    logic [63:0] ext_a_s;
    logic [63:0] ext_b_s;
    logic [63:0] prod_s;
    logic        div_done_s;
    logic [31:0] div_quo_s;
    logic [31:0] div_rem_s;

    // Decode of the incoming EX instruction
    always_comb begin
        sel_div_s    = is_div_sel(alu_sel);
        sel_signed_s = is_signed_sel(alu_sel);
        start_s      = op_valid & (w_hilo_ena == HILO_W_BOTH) & is_muldiv_sel(alu_sel);
        accept_s     = (state_r == ST_IDLE) & start_s & ~flush;
`ifdef MULDIV_DIV_EARLY_OUT_EN
        early_s      = sel_div_s & ((src_b == 32'd0) |
                       (abs32(src_a, sel_signed_s) < abs32(src_b, sel_signed_s)));
`else
        early_s      = 1'b0;
`endif
        div_start_s  = accept_s & sel_div_s & ~early_s;
    end

    // Full 64-bit product of the latched operands (sign-extended when signed)
    always_comb begin
        ext_a_s = {{32{signed_r & a_r[31]}}, a_r};
        ext_b_s = {{32{signed_r & b_r[31]}}, b_r};
        prod_s  = ext_a_s * ext_b_s;
    end

    div_radix2 u_div (
        .clk       (clk),
        .rst       (rst),
        .abort     (flush),
        .start     (div_start_s),
        .is_signed (sel_signed_s),
        .dividend  (src_a),
        .divisor   (src_b),
        .done      (div_done_s),
        .quotient  (div_quo_s),
        .remainder (div_rem_s)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic; flush returns to IDLE from anywhere
    always_comb begin
        state_nx_s = state_r;
        if (flush) begin
            state_nx_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!start_s) begin
                        state_nx_s = ST_IDLE;
                    end else if (!sel_div_s) begin
                        state_nx_s = ST_MUL;
                    end else if (early_s) begin
                        state_nx_s = ST_DONE;
                    end else begin
                        state_nx_s = ST_DIV;
                    end
                end
                ST_MUL: begin
                    if (cnt_r == CNT_ZERO) begin
                        state_nx_s = ST_DONE;
                    end else begin
                        state_nx_s = ST_MUL;
                    end
                end
                ST_DIV: begin
                    if (cnt_r == CNT_ZERO) begin
                        state_nx_s = ST_DONE;
                    end else begin
                        state_nx_s = ST_DIV;
                    end
                end
                ST_DONE: state_nx_s = ST_IDLE;
                default: state_nx_s = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: stall from the accepting cycle through the last MUL/DIV cycle
    always_comb begin
        stall_req = ~flush & (((state_r == ST_IDLE) & start_s) |
                              (state_r == ST_MUL) | (state_r == ST_DIV));
        busy      = (state_r != ST_IDLE);
    end

    // Operand/control latch at accept and the shared cycle counter
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r    <= CNT_ZERO;
            a_r      <= 32'd0;
            b_r      <= 32'd0;
            signed_r <= 1'b0;
            is_div_r <= 1'b0;
            bzero_r  <= 1'b0;
            early_r  <= 1'b0;
        end else if (flush) begin
            cnt_r    <= CNT_ZERO;
        end else if (accept_s) begin
            a_r      <= src_a;
            b_r      <= src_b;
            signed_r <= sel_signed_s;
            is_div_r <= sel_div_s;
            bzero_r  <= (src_b == 32'd0);
            early_r  <= early_s;
            if (sel_div_s) begin
                cnt_r <= CNT_DIV_LOAD;
            end else begin
                cnt_r <= CNT_MUL_LOAD;
            end
        end else if ((state_r == ST_MUL) || (state_r == ST_DIV)) begin
            if (cnt_r == CNT_ZERO) begin
                cnt_r <= CNT_ZERO;
            end else begin
                cnt_r <= cnt_r - CNT_ONE;
            end
        end else begin
            cnt_r    <= cnt_r;
        end
    end

    // Product pipeline register, loaded on the last MUL cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_r <= 64'd0;
        end else if (!flush && (state_r == ST_MUL) && (cnt_r == CNT_ZERO)) begin
            prod_r <= prod_s;
        end else begin
            prod_r <= prod_r;
        end
    end

    // Architectural HI/LO: result write in DONE, MTHI/MTLO in IDLE
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_r <= 32'd0;
            lo_r <= 32'd0;
        end else if (flush) begin
            hi_r <= hi_r;
            lo_r <= lo_r;
        end else if (state_r == ST_DONE) begin
            if (!is_div_r) begin
                hi_r <= prod_r[63:32];
                lo_r <= prod_r[31:0];
            end else if (bzero_r) begin
                hi_r <= a_r;
                lo_r <= 32'hFFFF_FFFF;
            end else if (early_r) begin
                hi_r <= a_r;
                lo_r <= 32'd0;
            end else if (div_done_s) begin
                hi_r <= div_rem_s;
                lo_r <= div_quo_s;
            end else begin
                hi_r <= hi_r;
                lo_r <= lo_r;
            end
        end else if ((state_r == ST_IDLE) && op_valid) begin
            case (w_hilo_ena)
                HILO_W_HI: hi_r <= src_a;
                HILO_W_LO: lo_r <= src_a;
                default: begin
                    hi_r <= hi_r;
                    lo_r <= lo_r;
                end
            endcase
        end else begin
            hi_r <= hi_r;
            lo_r <= lo_r;
        end
    end

    assign hi_out = hi_r;
    assign lo_out = lo_r;

endmodule

// File: doc/hilo_muldiv.md
Name: hilo_muldiv

Overview:
- Execute-side consumer of the decode stage's HI/LO controls (`alu_sel` = DIV/DIVU/MULT/MULTU, `w_hilo_ena`).
- Performs multi-cycle multiply and divide, and holds the architectural HI/LO registers.
- Raises a stall request that freezes the pipeline until the result is written.
- Sits beside the ALU in the EX stage; `hi_out`/`lo_out` feed the MFHI/MFLO result mux.

Parameters:
- MUL_CYCLES, 2: cycles spent in the MUL state (≥1); the product is registered at its end.
- DIV_ITERS, 32: restoring-divider iterations, one quotient bit per cycle; fixed at 32 for 32-bit operands.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  pipeline flush; cancels any in-flight operation
- op_valid  in  1  an instruction in EX is valid this cycle
- alu_sel  in  6  ALU operation code; uses the shared `ALU_SEL_*` encodings
- w_hilo_ena  in  2  [1]=write HI, [0]=write LO; 11 = mul/div, 10 = MTHI, 01 = MTLO
- src_a  in  32  rs operand (dividend / multiplicand / MTHI-MTLO data)
- src_b  in  32  rt operand (divisor / multiplier)
- stall_req  out  1  hold IF/ID/EX; the EX instruction must be re-presented unchanged
- busy  out  1  state ≠ IDLE
- hi_out  out  32  current HI register
- lo_out  out  32  current LO register

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: state=IDLE, counter=0, HI=0, LO=0, stall_req=0, busy=0.
- States: IDLE, MUL, DIV, DONE.
- Start condition: start = op_valid & w_hilo_ena==11 & alu_sel ∈ {MULT, MULTU, DIV, DIVU}.
- IDLE, start, no flush:
  - Latch operands, signedness and op.
  - Go to MUL (counter=MUL_CYCLES-1) or DIV (counter=31).
  - stall_req=1 combinationally in this same cycle.
- MUL:
  - Product = 64-bit signed (MULT) or unsigned (MULTU) product of the latched operands.
  - Decrement counter; at 0, register the product and go to DONE.
- DIV:
  - Operate on magnitudes: |a|, |b| when signed.
  - Each cycle, shift {rem, quo} left 1; trial-subtract |b|; if non-negative, commit and set quo[0]=1.
  - At counter=0, go to DONE.
- DONE:
  - stall_req=0.
  - At the clock edge, write HI=rem and LO=quo (div), or HI=prod[63:32] and LO=prod[31:0] (mul); then go to IDLE.
  - The stalled instruction advances in this cycle; its start is ignored because state≠IDLE.
- Signed divide fix-up:
  - quotient negated when sign(a)≠sign(b);
  - remainder takes sign(a).
- Divide by zero: HI=src_a (raw, latched), LO=32'hFFFF_FFFF, for both DIV and DIVU; no exception.
- Latency: DIV takes 34 cycles from accept to HI/LO visible (33 stall cycles); MUL takes MUL_CYCLES+2.
- stall_req = (IDLE & start & ~flush) | MUL | DIV.
- MTHI/MTLO:
  - In IDLE with op_valid and w_hilo_ena=10 (01), and no flush, HI (LO) <= src_a at the next edge.
  - Takes a single cycle with no stall.
  - w_hilo_ena=11 with a non-mul/div alu_sel writes nothing.
- Flush:
  - Highest priority after rst.
  - From any state: go to IDLE, drop stall_req the same cycle, leave HI/LO unchanged, write nothing.
- Reset mid-operation: identical to reset values; the operation is lost.
- hi_out/lo_out are the register values only; no bypass of the value being written in DONE (MFHI forwarding is handled by the hazard unit via the stall).

Optional Feature:
- MULDIV_DIV_EARLY_OUT_EN.
- Defined: at accept, if src_b==0 or |a|<|b| (magnitude compare), skip DIV and go straight to DONE with quo=0, rem=a.
  - Divide by zero keeps HI=src_a, LO=FFFF_FFFF.
  - Latency is 2 cycles.
- Undefined: every divide takes the full 32 iterations.

Decomposition:
- `ALU_SEL_DIV`/`DIVU`/`MULT`/`MULTU` and the `w_hilo_ena` encodings come from the shared decode definitions header; no local copies.
- Local state encodings live in the same header.
- One natural sub-module: `div_radix2` (iterative restoring divider with start/done handshake).
- Multiply stays inline using the `*` operator with pipeline registers.

Test Plan:
- DIV, a=-7 (FFFF_FFF9), b=2 -> stall_req high 33 cycles; then LO=FFFF_FFFD, HI=FFFF_FFFF.
- MULTU, a=b=FFFF_FFFF -> after MUL_CYCLES+2 cycles, HI=FFFF_FFFE, LO=0000_0001; MULT, a=-2, b=3 -> HI=FFFF_FFFF, LO=FFFF_FFFA.
- DIVU, a=100, b=0 -> HI=0000_0064, LO=FFFF_FFFF; with MULDIV_DIV_EARLY_OUT_EN, stall lasts 1 cycle.
- MTHI 1234_5678 then MTLO 9ABC_DEF0 on consecutive cycles -> no stall; HI and LO updated one edge later each.
- DIV started with HI=LO=0000_0011, flush at iteration 10 -> stall_req drops the same cycle, state=IDLE, HI/LO still 0000_0011.
- rst asserted during MUL -> next cycle HI=LO=0, busy=0, stall_req=0; an immediately following DIVU 9/4 -> LO=2, HI=1.
